// File: rtl/dcf77_frame_decoder.sv
// DCF77 second/minute decoder: times carrier-reduction pulses in ms ticks, classifies
// bits, locks to the minute marker and delivers the 59-bit frame with its parity verdict.
module dcf77_frame_decoder #(
  parameter int DIV      = 1500,
  parameter int POL      = 1,
  parameter int T0_MIN   = 40,
  parameter int T0_MAX   = 130,
  parameter int T1_MIN   = 140,
  parameter int T1_MAX   = 250,
  parameter int SEC_MIN  = 900,
  parameter int SEC_MAX  = 1100,
  parameter int MARK_MIN = 1800,
  parameter int MARK_MAX = 2200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        q,
  input  logic        strobe,
  output logic        bit_valid,
  output logic        bit_value,
  output logic [5:0]  bit_index,
  output logic        frame_valid,
  output logic [58:0] frame,
  output logic        parity_ok,
  output logic        locked,
  output logic        error
);

  localparam logic        POL_L      = 1'(POL);
  localparam logic [10:0] DIV_M1     = 11'(DIV - 1);
  localparam logic [11:0] T0_MIN_W   = 12'(T0_MIN);
  localparam logic [11:0] T0_MAX_W   = 12'(T0_MAX);
  localparam logic [11:0] T1_MIN_W   = 12'(T1_MIN);
  localparam logic [11:0] T1_MAX_W   = 12'(T1_MAX);
  localparam logic [11:0] SEC_MIN_W  = 12'(SEC_MIN);
  localparam logic [11:0] SEC_MAX_W  = 12'(SEC_MAX);
  localparam logic [11:0] MARK_MIN_W = 12'(MARK_MIN);
  localparam logic [11:0] MARK_MAX_W = 12'(MARK_MAX);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t      state_r;
  logic        lvl_r;
  logic [10:0] pre_r;
  logic [11:0] wcnt_r;
  logic [11:0] pcnt_r;
  logic [58:0] frame_reg_r;

  logic        act_s, start_s, stop_s, tick_s, loss_s;
  logic        is_b0_s, is_b1_s, is_sec_s, is_mark_s;
  logic [11:0] wcnt_inc_s, pcnt_inc_s;

  // Start-of-minute bit, start-of-time bit and the three even-parity groups
  function automatic logic frame_check(input logic [58:0] f);
    frame_check = (f[0] == 1'b0) && (f[20] == 1'b1) &&
                  (^f[28:21] == 1'b0) && (^f[35:29] == 1'b0) && (^f[58:36] == 1'b0);
  endfunction

  assign locked = (state_r == LOCK);

  // Edge detection, tick generation and classification of the current counts
  always_comb begin
    act_s      = (q == POL_L);
    start_s    = strobe && act_s && !lvl_r;
    stop_s     = strobe && !act_s && lvl_r;
    tick_s     = strobe && (pre_r == DIV_M1);
    wcnt_inc_s = (wcnt_r == 12'hFFF) ? wcnt_r : wcnt_r + 12'd1;
    pcnt_inc_s = (pcnt_r == 12'hFFF) ? pcnt_r : pcnt_r + 12'd1;
    is_b0_s    = (wcnt_r >= T0_MIN_W) && (wcnt_r <= T0_MAX_W);
    is_b1_s    = (wcnt_r >= T1_MIN_W) && (wcnt_r <= T1_MAX_W);
    is_sec_s   = (pcnt_r >= SEC_MIN_W) && (pcnt_r <= SEC_MAX_W);
    is_mark_s  = (pcnt_r >= MARK_MIN_W) && (pcnt_r <= MARK_MAX_W);
    // next tick would carry pcnt past the marker window: carrier lost
    loss_s     = tick_s && !start_s && (pcnt_r == MARK_MAX_W);
  end

  // Sampling, prescaler, width/period counters, lock state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= HUNT;
      lvl_r       <= 1'b0;
      pre_r       <= 11'd0;
      wcnt_r      <= 12'd0;
      pcnt_r      <= 12'd0;
      frame_reg_r <= 59'd0;
      bit_valid   <= 1'b0;
      bit_value   <= 1'b0;
      bit_index   <= 6'd0;
      frame_valid <= 1'b0;
      frame       <= 59'd0;
      parity_ok   <= 1'b0;
      error       <= 1'b0;
    end else begin
      bit_valid   <= 1'b0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
      if (strobe) begin
        lvl_r <= act_s;
        if (start_s) begin
          pre_r  <= 11'd0;
          wcnt_r <= 12'd0;
          pcnt_r <= 12'd0;
        end else begin
          pre_r <= tick_s ? 11'd0 : pre_r + 11'd1;
          if (tick_s) begin
            pcnt_r <= pcnt_inc_s;
            if (lvl_r) begin
              wcnt_r <= wcnt_inc_s;
            end
          end
        end
        case (state_r)
          HUNT: begin
            if (start_s && is_mark_s) begin
              state_r   <= LOCK;
              bit_index <= 6'd0;
            end
          end
          LOCK: begin
            if (start_s) begin
              if (is_mark_s) begin
                bit_index <= 6'd0;
                if (bit_index == 6'd59) begin
                  frame       <= frame_reg_r;
                  frame_valid <= 1'b1;
                  parity_ok   <= frame_check(frame_reg_r);
                end else begin
                  error <= 1'b1;
                end
              end else if (!is_sec_s) begin
                error   <= 1'b1;
                state_r <= HUNT;
              end
            end else if (stop_s) begin
              if (is_b0_s || is_b1_s) begin
                bit_valid <= 1'b1;
                bit_value <= is_b1_s;
                if (bit_index < 6'd59) begin
                  frame_reg_r[bit_index] <= is_b1_s;
                end
                if (bit_index < 6'd60) begin
                  bit_index <= bit_index + 6'd1;
                end
              end else begin
                error     <= 1'b1;
                state_r   <= HUNT;
                bit_index <= 6'd0;
              end
            end
            if (loss_s) begin
              error   <= 1'b1;
              state_r <= HUNT;
            end
          end
          default: state_r <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Randomized bench for dcf77_frame_decoder: time-scaled DCF77 seconds with random strobe
// gaps, checked every strobe against a strobe-count reference model.
module tb_dcf77_frame_decoder;

  localparam int DIV      = 4;
  localparam int T0_MIN   = 4;
  localparam int T0_MAX   = 13;
  localparam int T1_MIN   = 14;
  localparam int T1_MAX   = 25;
  localparam int SEC_MIN  = 45;
  localparam int SEC_MAX  = 55;
  localparam int MARK_MIN = 90;
  localparam int MARK_MAX = 110;

  logic        clk = 1'b0;
  logic        reset;
  logic        q;
  logic        strobe;
  logic        bit_valid, bit_value, frame_valid, parity_ok, locked, error;
  logic [5:0]  bit_index;
  logic [58:0] frame;

  always #5 clk = ~clk;

  dcf77_frame_decoder #(
    .DIV(DIV), .POL(1), .T0_MIN(T0_MIN), .T0_MAX(T0_MAX), .T1_MIN(T1_MIN), .T1_MAX(T1_MAX),
    .SEC_MIN(SEC_MIN), .SEC_MAX(SEC_MAX), .MARK_MIN(MARK_MIN), .MARK_MAX(MARK_MAX)
  ) dut (
    .clk(clk), .reset(reset), .q(q), .strobe(strobe),
    .bit_valid(bit_valid), .bit_value(bit_value), .bit_index(bit_index),
    .frame_valid(frame_valid), .frame(frame), .parity_ok(parity_ok),
    .locked(locked), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0, err_cnt = 0, fv_cnt = 0;

  // reference model: strobes since the last pulse start, lock flag, bit slot, frame store
  logic        m_lvl, m_locked, e_bval, e_par;
  int          m_k, m_idx;
  logic [58:0] m_fr, e_frame;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit even_ones(input logic [58:0] f, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(f[i]);
    return (n % 2) == 0;
  endfunction

  function automatic logic model_parity(input logic [58:0] f);
    return (f[0] == 1'b0) && (f[20] == 1'b1) && even_ones(f, 21, 28) &&
           even_ones(f, 29, 35) && even_ones(f, 36, 58);
  endfunction

  task automatic model_reset();
    m_lvl = 1'b0; m_locked = 1'b0; e_bval = 1'b0; e_par = 1'b0;
    m_k = 0; m_idx = 0; m_fr = 59'd0; e_frame = 59'd0;
  endtask

  task automatic model_step(input logic a, output logic ebv, output logic eerr, output logic efv);
    logic st, sp;
    int   meas;
    st = a && !m_lvl;
    sp = !a && m_lvl;
    m_k++;
    // whole ticks completed before this strobe since the pulse start (or reset)
    meas = (m_k - 1) / DIV;
    if (meas > 4095) meas = 4095;
    ebv = 1'b0; eerr = 1'b0; efv = 1'b0;
    if (st) begin
      if (m_locked) begin
        if (in_rng(meas, MARK_MIN, MARK_MAX)) begin
          if (m_idx == 59) begin
            efv = 1'b1; e_frame = m_fr; e_par = model_parity(m_fr);
          end else begin
            eerr = 1'b1;
          end
          m_idx = 0;
        end else if (!in_rng(meas, SEC_MIN, SEC_MAX)) begin
          eerr = 1'b1; m_locked = 1'b0;
        end
      end else if (in_rng(meas, MARK_MIN, MARK_MAX)) begin
        m_locked = 1'b1; m_idx = 0;
      end
      m_k = 0;
    end else if (sp && m_locked) begin
      if (in_rng(meas, T0_MIN, T0_MAX) || in_rng(meas, T1_MIN, T1_MAX)) begin
        ebv = 1'b1;
        e_bval = in_rng(meas, T1_MIN, T1_MAX);
        if (m_idx < 59) m_fr[m_idx] = e_bval;
        if (m_idx < 60) m_idx++;
      end else begin
        eerr = 1'b1; m_locked = 1'b0; m_idx = 0;
      end
    end
    if (!st && m_locked && m_k == (MARK_MAX + 1) * DIV) begin
      eerr = 1'b1; m_locked = 1'b0;
    end
    m_lvl = a;
  endtask

  task automatic do_sample(input logic a);
    int   idle;
    logic ebv, eerr, efv;
    idle = ($urandom_range(0, 3) == 0) ? 1 : 0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk); strobe = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_pulses", {61'd0, bit_valid, error, frame_valid}, 64'd0);
    end
    @(negedge clk); q = a; strobe = 1'b1;
    @(posedge clk); #1;
    model_step(a, ebv, eerr, efv);
    bv_cnt  += int'(bit_valid);
    err_cnt += int'(error);
    fv_cnt  += int'(frame_valid);
    check_eq("strobe_outputs", {53'd0, bit_valid, error, frame_valid, locked, bit_value, bit_index},
             {53'd0, ebv, eerr, efv, m_locked, e_bval, 6'(m_idx)});
    if (frame_valid || efv) begin
      check_eq("frame_parity", {4'd0, parity_ok, frame}, {4'd0, e_par, e_frame});
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; strobe = 1'b0; q = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctl", {54'd0, bit_valid, bit_value, bit_index, frame_valid, parity_ok, locked, error}, 64'd0);
    check_eq("reset_frame", {5'd0, frame}, 64'd0);
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic send_sec(input int w, input int p);
    for (int i = 0; i < w * DIV; i++) do_sample(1'b1);
    for (int i = 0; i < (p - w) * DIV; i++) do_sample(1'b0);
  endtask

  function automatic int w_bit(input logic b);
    return b ? int'($urandom_range(16, 24)) : int'($urandom_range(6, 12));
  endfunction

  function automatic int p_sec();
    return int'($urandom_range(47, 53));
  endfunction

  function automatic int p_mark();
    return int'($urandom_range(95, 105));
  endfunction

  function automatic logic [58:0] make_frame();
    logic [58:0] v;
    v[31:0]  = $urandom;
    v[58:32] = 27'($urandom);
    v[0]  = 1'b0;
    v[20] = 1'b1;
    v[28] = ^v[27:21];
    v[35] = ^v[34:29];
    v[58] = ^v[57:36];
    return v;
  endfunction

  // seconds first..58 of a minute; second 58 is followed by the missing-pulse gap
  task automatic send_bits(input logic [58:0] v, input int first);
    for (int n = first; n < 59; n++) send_sec(w_bit(v[n]), (n == 58) ? p_mark() : p_sec());
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [58:0] vec1, vec2;
    int b0, e0, f0;
    reset = 1'b1; q = 1'b0; strobe = 1'b0;
    model_reset();
    do_reset();

    // hunting: normal seconds never produce bits or errors
    b0 = bv_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_sec(w_bit(1'($urandom)), p_sec());
    send_sec(w_bit(1'b0), p_mark());
    check_eq("hunt_no_bits", 64'(bv_cnt - b0), 64'd0);
    check_eq("hunt_no_error", 64'(err_cnt - e0), 64'd0);
    check_eq("hunt_unlocked", {63'd0, locked}, 64'd0);

    // full valid frame
    vec1 = make_frame();
    b0 = bv_cnt; e0 = err_cnt;
    send_bits(vec1, 0);
    check_eq("frame1_bit_count", 64'(bv_cnt - b0), 64'd59);
    vec2 = vec1;
    vec2[28] = ~vec2[28];
    f0 = fv_cnt;
    send_sec(w_bit(vec2[0]), p_sec());
    check_eq("frame1_valid_count", 64'(fv_cnt - f0), 64'd1);
    check_eq("frame1_data", {5'd0, frame}, {5'd0, vec1});
    check_eq("frame1_parity_ok", {63'd0, parity_ok}, 64'd1);
    check_eq("frame1_locked", {63'd0, locked}, 64'd1);
    check_eq("frame1_no_error", 64'(err_cnt - e0), 64'd0);

    // same frame with a flipped parity group
    f0 = fv_cnt; e0 = err_cnt;
    send_bits(vec2, 1);
    send_sec(w_bit(1'b0), p_sec());
    check_eq("frame2_valid_count", 64'(fv_cnt - f0), 64'd1);
    check_eq("frame2_data", {5'd0, frame}, {5'd0, vec2});
    check_eq("frame2_parity_bad", {63'd0, parity_ok}, 64'd0);
    check_eq("frame2_no_error", 64'(err_cnt - e0), 64'd0);

    // over-wide pulse drops lock
    b0 = bv_cnt; e0 = err_cnt;
    send_sec(30, p_sec());
    check_eq("width_err_count", 64'(err_cnt - e0), 64'd1);
    check_eq("width_err_no_bit", 64'(bv_cnt - b0), 64'd0);
    check_eq("width_err_unlocked", {63'd0, locked}, 64'd0);

    // relock, then a marker after only 40 bits
    send_sec(w_bit(1'b0), p_mark());
    b0 = bv_cnt;
    for (int n = 0; n < 40; n++) send_sec(w_bit(1'($urandom)), (n == 39) ? p_mark() : p_sec());
    check_eq("short_bits", 64'(bv_cnt - b0), 64'd40);
    e0 = err_cnt; f0 = fv_cnt;
    send_sec(w_bit(1'b0), p_sec());
    check_eq("short_error", 64'(err_cnt - e0), 64'd1);
    check_eq("short_no_frame", 64'(fv_cnt - f0), 64'd0);
    check_eq("short_locked", {63'd0, locked}, 64'd1);

    // reset in the middle of a frame
    for (int n = 0; n < 5; n++) send_sec(w_bit(1'($urandom)), p_sec());
    do_reset();

    // signal loss while locked
    send_sec(w_bit(1'b0), p_mark());
    send_sec(w_bit(1'b0), p_sec());
    check_eq("loss_pre_locked", {63'd0, locked}, 64'd1);
    e0 = err_cnt;
    send_sec(w_bit(1'b0), 120);
    check_eq("loss_error", 64'(err_cnt - e0), 64'd1);
    check_eq("loss_unlocked", {63'd0, locked}, 64'd0);
    send_sec(w_bit(1'b0), p_sec());
    check_eq("loss_single_error", 64'(err_cnt - e0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcf77_frame_decoder.md
Name: dcf77_frame_decoder

Overview:
- Consumes the retimed data `q` and the sample `strobe` from the clock-and-data-recovery stage.
- Measures carrier-reduction pulse widths and the pulse-start periods, in millisecond ticks.
- Classifies each second pulse as bit 0, bit 1 or error, and detects the minute marker.
- Assembles the 59-bit DCF77 time frame, checks parity and hands the frame to the time/date unpacker downstream.

Parameters:
- DIV, 1500, number of strobes per tick (1.5 MHz strobe gives 1 ms ticks)
- POL, 1, level of `q` during a carrier-reduction pulse
- T0_MIN, 40, minimum pulse width in ticks for bit 0
- T0_MAX, 130, maximum pulse width in ticks for bit 0
- T1_MIN, 140, minimum pulse width in ticks for bit 1
- T1_MAX, 250, maximum pulse width in ticks for bit 1
- SEC_MIN, 900, minimum normal pulse-start period in ticks
- SEC_MAX, 1100, maximum normal pulse-start period in ticks
- MARK_MIN, 1800, minimum minute-marker period in ticks
- MARK_MAX, 2200, maximum minute-marker period in ticks; also the signal-loss timeout

Ports:
- clk  in  1  system clock, 24 MHz
- reset  in  1  synchronous, active-high
- q  in  1  retimed data from the CDR stage
- strobe  in  1  one-clk sample enable from the CDR stage
- bit_valid  out  1  one-clk pulse: a bit was classified
- bit_value  out  1  classified bit; valid while bit_valid is high
- bit_index  out  6  position of the current bit in the frame, 0..60
- frame_valid  out  1  one-clk pulse: a complete frame is available
- frame  out  59  frame bits; bit n is second n; holds until the next frame_valid
- parity_ok  out  1  frame checks passed; updated with frame_valid
- locked  out  1  decoder is synchronised to the minute marker
- error  out  1  one-clk pulse: protocol violation while locked

Behaviour:
- Reset: all outputs 0, all counters 0, state HUNT, sampled level `lvl` = inactive.
- Input sampling: `q` is used only in clks where strobe=1. `act = (q==POL)`; `lvl <= act` on each strobe. Pulse start = `act && !lvl`; pulse end = `!act && lvl`.
- Prescaler: 11-bit counter, incremented on each strobe. `tick` = strobe && pre==DIV-1, which wraps pre to 0.
- Pulse start clears pre to 0. The edge takes priority over tick in the same clk.
- wcnt (12-bit, saturating at 4095):
  - cleared at pulse start;
  - incremented on each tick while lvl is active.
- pcnt (12-bit, saturating at 4095):
  - cleared at pulse start;
  - incremented on each tick.
- Pulse end classification:
  - T0_MIN<=wcnt<=T0_MAX gives bit 0;
  - T1_MIN<=wcnt<=T1_MAX gives bit 1;
  - any other width is a width error.
- Pulse start classification:
  - SEC_MIN<=pcnt<=SEC_MAX is a normal second;
  - MARK_MIN<=pcnt<=MARK_MAX is a minute marker;
  - any other period is a period error.
- States: HUNT and LOCK.
- HUNT:
  - locked=0; bit_valid and error are suppressed.
  - A minute marker gives LOCK, bit_index<=0.
  - Nothing else causes a transition.
- LOCK (locked=1):
  - Valid bit at pulse end:
    - bit_valid=1 for one clk with bit_value;
    - if bit_index<59, then frame_reg[bit_index]<=bit_value;
    - bit_index<=min(bit_index+1,60).
  - Width error: error=1, go to HUNT, bit_index<=0.
  - Normal period: no action.
  - Period error: error=1, go to HUNT.
  - Minute marker with bit_index==59:
    - frame<=frame_reg;
    - frame_valid=1 for one clk;
    - parity_ok computed;
    - bit_index<=0; stay in LOCK.
  - Minute marker with bit_index!=59 (including leap-second 60): error=1, no frame_valid, bit_index<=0, stay in LOCK.
  - pcnt reaching MARK_MAX+1 (signal loss): error=1 once, go to HUNT.
- parity_ok requires all of:
  - frame_reg[0]==0;
  - frame_reg[20]==1;
  - even parity over bits 21..28;
  - even parity over bits 29..35;
  - even parity over bits 36..58.
- Latency: bit_valid, frame_valid and error are registered and rise exactly one clk after the strobe clk that sampled the triggering edge.
- Registered outputs:
  - bit_index, locked, frame and parity_ok update in that same clk;
  - bit_value is registered with bit_valid and holds its last value otherwise.
- No strobe means no state change except reset. strobe held high for consecutive clks is legal, one sample per clk.
- Reset mid-frame discards the partial frame; frame and parity_ok clear to 0.

Test Plan:
- DIV=4: marker, then 59 second pulses (100/200 ticks per the encoded time), then marker -> 59 bit_valid pulses with the correct values; frame_valid=1 for one clk with frame equal to the encoded vector; parity_ok=1; locked stays 1.
- Same frame with bit 28 flipped -> frame_valid=1, parity_ok=0, no error pulse.
- Locked; one pulse 300 ticks wide -> error=1 one clk after the pulse-end strobe; locked=0; bit_valid not asserted.
- Locked; marker after only 40 bits -> error=1, frame_valid=0, bit_index=0, locked=1.
- Locked; q held inactive for 2201 ticks -> single error pulse at pcnt=2201; locked=0.
- From reset, 5 normal seconds then a marker -> no bit_valid or error before the marker; locked rises one clk after the marker's start strobe.
